// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub accumulate stage.
//   WIDTH_DEFAULT : default datapath width
//   OP_*          : command opcodes carried on in_op
//   fifo_entry_t  : one output FIFO slot {ovf, data}
package addsub_pkg;
  localparam int WIDTH_DEFAULT = 36;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_ADD   = 2'd2;
  localparam logic [1:0] OP_SUB   = 2'd3;

  typedef struct packed {
    logic                     ovf;
    logic [WIDTH_DEFAULT-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract core.
//   a, b : operands
//   sub  : 1 = a - b, 0 = a + b
//   sum  : result modulo 2^WIDTH (carry out dropped)
//   ovf  : two's-complement overflow
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH-1:0] b_eff;

  // Subtract as a + ~b + 1 so a single adder serves both operations.
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
  // Overflow: adder inputs agree in sign, result sign differs.
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/addsub_acc_stage.sv
// Accumulate stage around addsub_core with a 2-entry registered output FIFO.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : command handshake (in_op, in_data)
//   out_valid/out_ready  : result handshake (out_data, out_ovf)
//   acc                  : live accumulator register
module addsub_acc_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc
);
  typedef struct packed {
    logic             ovf;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [WIDTH-1:0] sum;
  logic             core_ovf;
  entry_t           nxt;
  entry_t           mem [2];
  logic             wptr, rptr;
  logic [1:0]       count;
  logic             push, pop;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a   (acc),
    .b   (in_data),
    .sub (in_op == OP_SUB),
    .sum (sum),
    .ovf (core_ovf)
  );

  always_comb begin
    nxt = '0;
    case (in_op)
      OP_CLEAR: nxt = '0;
      OP_LOAD:  nxt.data = in_data;
      default: begin
        nxt.data = sum;
        nxt.ovf  = core_ovf;
      end
    endcase
  end

  // A full FIFO still accepts when the head is leaving this cycle.
  assign in_ready  = (count < 2'(DEPTH)) || out_ready;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rptr].data;
  assign out_ovf   = mem[rptr].ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        acc       <= nxt.data;
        mem[wptr] <= nxt;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_acc_stage.sv
module tb_addsub_acc_stage;
  localparam int W = 36;
  localparam logic [1:0] CLR = 2'd0, LD = 2'd1, AD = 2'd2, SB = 2'd3;
  localparam longint MAXP = (64'sd1 <<< 35) - 1;
  localparam longint MINN = -(64'sd1 <<< 35);

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [1:0]   in_op;
  logic [W-1:0] in_data, out_data, acc;

  int checks = 0, errors = 0;

  addsub_acc_stage #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: accumulator plus queue of pending results
  typedef struct { logic [W-1:0] d; logic o; } ent_t;
  ent_t         q[$];
  logic [W-1:0] acc_m;

  typedef struct { logic [1:0] op; logic [W-1:0] d; logic [W-1:0] ed; logic eo; } vec_t;
  vec_t vt[$];

  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endfunction

  function automatic void model_apply(input logic [1:0] op, input logic [W-1:0] d);
    longint sa, sd, r;
    ent_t e;
    sa = longint'($signed(acc_m));
    sd = longint'($signed(d));
    e.o = 1'b0;
    case (op)
      CLR: e.d = '0;
      LD:  e.d = d;
      default: begin
        r   = (op == AD) ? sa + sd : sa - sd;
        e.o = (r > MAXP) || (r < MINN);
        e.d = r[W-1:0];
      end
    endcase
    acc_m = e.d;
    q.push_back(e);
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = 36'h7_FFFF_FFFF;
      1: v = 36'h8_0000_0000;
      2: v = '0;
      3: v = {W{1'b1}};
      default: v = {4'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // One clock: drive, check against model, take the edge, update model.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                       input logic ordy);
    logic exp_rdy, do_push, do_pop;
    in_valid = v; in_op = op; in_data = d; out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("acc", acc, acc_m);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_ovf", out_ovf, q[0].o);
    end
    do_push = v && exp_rdy;
    do_pop  = (q.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) model_apply(op, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    q.delete(); acc_m = '0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_acc", acc, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 0; in_op = 0; in_data = 0; out_ready = 0; rst_n = 0;
    acc_m = '0;
    #3;
    do_reset();

    // reset mid-stream with the FIFO full
    cycle(1, LD, 36'h123, 0);
    cycle(1, AD, 36'h456, 0);
    chk("pre_rst_full", in_ready, 1'b0);
    do_reset();
    cycle(1, LD, 36'd5, 0);
    chk("post_rst_load", out_data, 36'd5);
    chk("post_rst_valid", out_valid, 1'b1);
    cycle(0, CLR, '0, 1);

    // table-driven ops streaming with out_ready=1
    vt.push_back('{LD,  36'h0_0000_0010, 36'h0_0000_0010, 1'b0});
    vt.push_back('{AD,  36'h5,           36'h0_0000_0015, 1'b0});
    vt.push_back('{SB,  36'h20,          36'hF_FFFF_FFF5, 1'b0});
    vt.push_back('{CLR, 36'h1234,        36'h0,           1'b0});
    vt.push_back('{LD,  36'h7_FFFF_FFFF, 36'h7_FFFF_FFFF, 1'b0});
    vt.push_back('{AD,  36'h1,           36'h8_0000_0000, 1'b1});
    vt.push_back('{LD,  36'h8_0000_0000, 36'h8_0000_0000, 1'b0});
    vt.push_back('{SB,  36'h1,           36'h7_FFFF_FFFF, 1'b1});
    vt.push_back('{AD,  36'h0,           36'h7_FFFF_FFFF, 1'b0});
    for (int i = 0; i < vt.size(); i++) begin
      cycle(1, vt[i].op, vt[i].d, 1);
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].ed);
      chk($sformatf("vec%0d_ovf", i), out_ovf, vt[i].eo);
    end
    cycle(0, CLR, '0, 1);

    // backpressure: third command held while full
    cycle(1, LD, 36'd1, 0);
    cycle(1, AD, 36'd1, 0);
    chk("bp_in_ready", in_ready, 1'b0);
    cycle(1, AD, 36'd1, 0);
    chk("bp_acc_held", acc, 36'd2);
    chk("bp_head_stable", out_data, 36'd1);
    cycle(1, AD, 36'd1, 1);
    chk("bp_pop2", out_data, 36'd2);
    cycle(0, CLR, '0, 1);
    chk("bp_pop3", out_data, 36'd3);
    cycle(0, CLR, '0, 1);
    chk("bp_empty", out_valid, 1'b0);

    // full FIFO with simultaneous push/pop, pointers wrapping
    cycle(1, LD, 36'd100, 0);
    cycle(1, AD, 36'd1, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, AD, rnd_data(), 1);
      out_ready = 1'b0;
      #1;
      chk("pp_still_full", in_ready, 1'b0);
      out_ready = 1'b1;
    end
    cycle(0, CLR, '0, 1);
    cycle(0, CLR, '0, 1);

    // random stress against the model
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), rnd_data(),
            1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) cycle(0, CLR, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_acc_stage.md
# addsub_acc_stage

Sequential accumulate stage wrapped around the 36-bit combinational add/subtract unit. It accepts a stream of opcode+operand commands over a valid/ready handshake and keeps a running accumulator. Each command's accumulator result, with a signed-overflow flag, is pushed into a 2-entry output FIFO with its own valid/ready handshake. It sits directly in front of the add/sub datapath: it supplies `a`/`b`/`sub` and consumes the sum.

## Interface
Parameters:
- `WIDTH`, 36, datapath width (accumulator, operand, result).
- `DEPTH`, 2, output FIFO entries; only 2 is required and verified.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  stage can accept a command this cycle.
- `in_op`  in  2  0=CLEAR, 1=LOAD, 2=ADD, 3=SUB.
- `in_data`  in  WIDTH  operand; ignored for CLEAR.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes the head this cycle.
- `out_data`  out  WIDTH  accumulator value after the command.
- `out_ovf`  out  1  signed overflow of that command (ADD/SUB only).
- `acc`  out  WIDTH  live accumulator register.

## Operation
- A command is accepted on a rising edge where `in_valid && in_ready`.
- Accumulator update on accept:
  - CLEAR → 0.
  - LOAD → `in_data`.
  - ADD → `acc + in_data`.
  - SUB → `acc - in_data`, computed as `acc + ~in_data + 1` through the add/sub core.
- All arithmetic is modulo 2^WIDTH; the carry out is discarded.
- `ovf` = two's-complement overflow: operands with the same sign (after the SUB inversion) and a result sign that differs. `ovf` is 0 for CLEAR/LOAD. It is not sticky.
- Every accepted command pushes `{new_acc, ovf}` into the FIFO. There is exactly one output per input, in order.
- FIFO: `count` 0..2; read/write pointers wrap at 2.
  - A pop happens when `out_valid && out_ready`.
  - `in_ready = (count < 2) || out_ready`, so when full, a simultaneous pop and push is allowed. `in_ready` therefore depends combinationally on `out_ready`. There is no combinational path from `in_valid` to any output.
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - Push into an empty FIFO while `out_ready=1`: the entry still appears registered; no fall-through.
- Back-to-back commands use the updated accumulator; there is no hazard bubble.
- Reset (any time, including mid-stream or while the FIFO is full): `acc=0`, `count=0`, pointers=0, `out_valid=0`, `out_data=0`, `out_ovf=0`, `in_ready=1`. In-flight FIFO entries are discarded.

## Timing
- Latency: a command accepted at edge N gives `acc` updated after edge N. If the FIFO was empty or popped, `out_valid=1` with that result after edge N.
- Throughput: 1 command/cycle while the consumer holds `out_ready=1`.
- With `out_ready=0`: two commands are accepted, then `in_ready=0` until a pop.
- `out_data`/`out_ovf` must hold stable while `out_valid && !out_ready`.
- The critical path is one WIDTH-bit add plus the FIFO write mux. It must close within one cycle.

## Structure
- Shared package `addsub_pkg`:
  - `WIDTH_DEFAULT=36`.
  - Opcode localparams `OP_CLEAR`, `OP_LOAD`, `OP_ADD`, `OP_SUB`.
  - Typedef for the FIFO entry `{logic ovf; logic [WIDTH-1:0] data}`.
- One sub-module, `addsub_core`: combinational `a`, `b`, `sub` → `sum`, `ovf`. It implements the invert-and-carry-in scheme. It is instantiated once and reused for ADD and SUB.
- The FIFO is inline: two entry registers, 1-bit pointers and a 2-bit count.

## Test plan
- Reset mid-stream: push 2 commands with `out_ready=0`, assert `rst_n=0` → `out_valid=0`, `acc=0`, `in_ready=1`. Then LOAD 5 → `out_data=5`.
- Basic ops with `out_ready=1`: LOAD 0x0_0000_0010, ADD 0x5, SUB 0x20, CLEAR → outputs 0x10, 0x15, 0xF_FFFF_FFF5, 0, all with `ovf=0`, one per cycle.
- Overflow: LOAD 0x7_FFFF_FFFF, ADD 1 → 0x8_0000_0000 with `ovf=1`. LOAD 0x8_0000_0000, SUB 1 → 0x7_FFFF_FFFF with `ovf=1`. ADD 0 → `ovf=0`.
- Backpressure and full boundary: `out_ready=0`, stream LOAD 1, ADD 1, ADD 1 → the third is held (`in_ready=0`) and `acc=2`. Raise `out_ready` → pops 1, then 2, then 3, in order, with no loss or duplication.
- Simultaneous push/pop when full: FIFO full, `out_ready=1` and `in_valid=1` in the same cycle → `count` stays 2, the head advances and the new result lands at the tail. Run 8 cycles with pointers wrapping, checked against a scoreboard.
- Random stress: 10k random ops and operands, with random `in_valid`/`out_ready` → every output matches the reference model modulo 2^36, including `ovf`.
